// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one signed sequential multiplier between two requesters.
// Latency: ack 1 cycle after req is sampled in IDLE, start 1 later, done 1 cycle after mult_done is accepted.
// Backpressure: req is a level held until ack; req is only sampled in IDLE, so a busy arbiter simply stalls requesters.
module mult_share_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [DATA_W-1:0]   mp0,
    input  logic [DATA_W-1:0]   mc0,
    input  logic [DATA_W-1:0]   mp1,
    input  logic [DATA_W-1:0]   mc1,
    output logic                ack0,
    output logic                ack1,
    output logic                done0,
    output logic                done1,
    output logic [2*DATA_W-1:0] result,
    output logic                res_id,
    output logic                timeout_err,
    output logic                busy,
    output logic                mult_start,
    output logic [DATA_W-1:0]   mult_mp,
    output logic [DATA_W-1:0]   mult_mc,
    input  logic                mult_done,
    input  logic [2*DATA_W-2:0] mult_product
);

    localparam int PW = 2*DATA_W-1;
    localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state_q;
    logic                  prio_q;
    logic                  win_q;
    logic                  win_d;
    logic [7:0]            cnt_q;
    logic [PW-1:0]         prod_q;
    logic                  to_q;
    logic                  ack0_q;
    logic                  ack1_q;
    logic                  done0_q;
    logic                  done1_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  res_id_q;
    logic                  terr_q;
    logic                  busy_q;
    logic                  start_q;
    logic [DATA_W-1:0]     mp_q;
    logic [DATA_W-1:0]     mc_q;

    // Arbitration: a lone requester wins, under contention the priority pointer decides.
    always_comb begin
        win_d = 1'b0;
        if (req0 && req1) begin
            win_d = prio_q;
        end else begin
            win_d = req1;
        end
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            win_q    <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            to_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            result_q <= '0;
            res_id_q <= 1'b0;
            terr_q   <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            mp_q     <= '0;
            mc_q     <= '0;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            start_q <= 1'b0;
            // Lags the state by one cycle: rises with ack, falls the cycle after done.
            busy_q  <= (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        win_q   <= win_d;
                        state_q <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    mp_q    <= win_q ? mp1 : mp0;
                    mc_q    <= win_q ? mc1 : mc0;
                    ack0_q  <= ~win_q;
                    ack1_q  <= win_q;
                    terr_q  <= 1'b0;
                    state_q <= S_START;
                end
                S_START: begin
                    start_q <= 1'b1;
                    cnt_q   <= '0;
                    to_q    <= 1'b0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    // The first WAIT cycle ignores mult_done: it may still be the previous op's flag.
                    if (mult_done && (cnt_q != 8'd0)) begin
                        prod_q  <= mult_product;
                        state_q <= S_RESP;
                    end else if (cnt_q == TO_MAX) begin
                        prod_q  <= '0;
                        to_q    <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    // A zero magnitude is always reported as +0.
                    result_q <= {(mp_q[DATA_W-1] ^ mc_q[DATA_W-1]) & (|prod_q), prod_q};
                    res_id_q <= win_q;
                    done0_q  <= ~win_q;
                    done1_q  <= win_q;
                    terr_q   <= to_q;
                    prio_q   <= ~win_q;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign result      = result_q;
    assign res_id      = res_id_q;
    assign timeout_err = terr_q;
    assign busy        = busy_q;
    assign mult_start  = start_q;
    assign mult_mp     = mp_q;
    assign mult_mc     = mc_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural sequential multiplier.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_mult_share_arbiter;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 31;
    localparam int M_DLY   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic [7:0]  mp0 = '0;
    logic [7:0]  mc0 = '0;
    logic [7:0]  mp1 = '0;
    logic [7:0]  mc1 = '0;
    logic        ack0, ack1, done0, done1;
    logic [15:0] result;
    logic        res_id, timeout_err, busy, mult_start;
    logic [7:0]  mult_mp, mult_mc;

    logic        m_done = 1'b0;
    logic [14:0] m_prod = '0;
    int          m_cnt = 0;
    bit          m_hang = 1'b0;
    bit          m_ignore = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;

    mult_share_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .req1         (req1),
        .mp0          (mp0),
        .mc0          (mc0),
        .mp1          (mp1),
        .mc1          (mc1),
        .ack0         (ack0),
        .ack1         (ack1),
        .done0        (done0),
        .done1        (done1),
        .result       (result),
        .res_id       (res_id),
        .timeout_err  (timeout_err),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_mp      (mult_mp),
        .mult_mc      (mult_mc),
        .mult_done    (m_done),
        .mult_product (m_prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorders, sampled on the falling edge.
    always @(negedge clk) begin
        if (mult_start) start_cyc <= cyc;
        if (done0 || done1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [14:0] mag(logic [7:0] a, logic [7:0] b);
        int p;
        p = $signed(a) * $signed(b);
        if (p < 0) p = -p;
        return p[14:0];
    endfunction

    // Multiplier model: done is a level that drops on start and rises M_DLY cycles later.
    always @(posedge clk) begin
        if (mult_start && !m_ignore) begin
            m_done <= 1'b0;
            m_cnt  <= m_hang ? 0 : M_DLY;
        end else if (m_cnt == 1) begin
            m_done <= 1'b1;
            m_prod <= mag(mult_mp, mult_mc);
            m_cnt  <= 0;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int id, output int at);
        id = -1;
        at = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (ack0 || ack1) begin
                id = ack1 ? 1 : 0;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done0 || done1) begin
                at = cyc;
                break;
            end
        end
        chk("done_seen", 32'(at >= 0), 32'd1);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int id, at, dat, t0, dc;

        // Reset state
        tick();
        tick();
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flags", 32'({ack0, ack1, done0, done1, res_id, timeout_err, busy, mult_start}), 32'h0);
        chk("rst_ops", 32'({mult_mp, mult_mc}), 32'h0);
        rst_n = 1'b1;
        tick();

        // Single requester: -5 * 7
        mp0 = 8'hFB; mc0 = 8'h07; req0 = 1'b1; t0 = cyc;
        wait_ack(id, at);
        req0 = 1'b0;
        chk("t1_ack_id", 32'(id), 32'd0);
        chk("t1_ack_lat", 32'(at - t0), 32'd2);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        wait_done(dat);
        chk("t1_start_lat", 32'(start_cyc - at), 32'd1);
        chk("t1_done_lat", 32'(dat - start_cyc), 32'd11);
        chk("t1_result", 32'(result), 32'h8023);
        chk("t1_id_err_d0", 32'({res_id, timeout_err, done0, done1}), 32'b0010);
        tick();
        chk("t1_busy_fall", 32'(busy), 32'd0);

        // Contention after reset: strict alternation 0,1,0,1
        do_reset();
        mp0 = 8'h03; mc0 = 8'h05; mp1 = 8'h80; mc1 = 8'h80;
        req0 = 1'b1; req1 = 1'b1;
        wait_ack(id, at);
        chk("c_g1", 32'(id), 32'd0);
        req0 = 1'b0;
        wait_done(dat);
        chk("c_r1", 32'(result), 32'h000F);
        chk("c_id1", 32'(res_id), 32'd0);
        wait_ack(id, at);
        chk("c_g2", 32'(id), 32'd1);
        mp1 = 8'hFF; mc1 = 8'h01; req1 = 1'b1;
        mp0 = 8'hF0; mc0 = 8'h00; req0 = 1'b1;
        wait_done(dat);
        chk("c_r2", 32'(result), 32'h4000);
        chk("c_id2", 32'(res_id), 32'd1);
        wait_ack(id, at);
        chk("c_g3", 32'(id), 32'd0);
        chk("c_b2b", 32'(at - dat), 32'd2);
        req0 = 1'b0;
        wait_done(dat);
        chk("c_r3_zero", 32'(result), 32'h0000);
        wait_ack(id, at);
        chk("c_g4", 32'(id), 32'd1);
        req1 = 1'b0;
        wait_done(dat);
        chk("c_r4", 32'(result), 32'h8001);
        chk("c_id4", 32'(res_id), 32'd1);

        // Timeout: multiplier never finishes
        m_hang = 1'b1;
        mp0 = 8'h02; mc0 = 8'h03; req0 = 1'b1;
        wait_ack(id, at);
        req0 = 1'b0;
        wait_done(dat);
        chk("to_lat", 32'(dat - start_cyc), 32'd33);
        chk("to_err", 32'(timeout_err), 32'd1);
        chk("to_result", 32'(result), 32'h0);
        chk("to_done0", 32'(done0), 32'd1);
        m_hang = 1'b0;
        req0 = 1'b1;
        wait_ack(id, at);
        req0 = 1'b0;
        chk("to_clr", 32'(timeout_err), 32'd0);
        wait_done(dat);
        chk("to_next", 32'(result), 32'h0006);

        // Reset during WAIT with a stale mult_done held high
        mp0 = 8'h03; mc0 = 8'h04; req0 = 1'b1;
        wait_ack(id, at);
        req0 = 1'b0;
        wait_done(dat);
        chk("sr_pre", 32'(result), 32'h000C);
        m_ignore = 1'b1;
        mp0 = 8'h02; mc0 = 8'hFD; req0 = 1'b1;
        wait_ack(id, at);
        req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        dc = done_cnt;
        chk("sr_rst_result", 32'(result), 32'h0);
        chk("sr_rst_flags", 32'({ack0, ack1, done0, done1, res_id, timeout_err, busy, mult_start}), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("sr_no_done", 32'(done_cnt - dc), 32'd0);
        chk("sr_stale_hi", 32'(m_done), 32'd1);
        m_ignore = 1'b0;
        req0 = 1'b1;
        wait_ack(id, at);
        req0 = 1'b0;
        wait_done(dat);
        chk("sr_result", 32'(result), 32'h8006);
        chk("sr_lat", 32'(dat - start_cyc), 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
